// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   SEL_*   : Mem2RegSEL encodings for write-back source selection
//   state_t : MEM-stage controller states
package mem_stage_pkg;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Word alignment test on the two low address bits.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// Bus-wait timer for the MEM stage.
// Counts cycles spent waiting for a memory acknowledge and flags expiry.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous clear (takes priority over i_enable)
//   i_enable       : advance the count by one
//   o_expired      : count has reached TIMEOUT-1
module mem_bus_timer
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;
  logic             w_expired;

  assign w_expired = (r_count == CNT_W'(TIMEOUT - 1));
  assign o_expired = w_expired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_expired) begin
      // Saturate at the terminal value; the FSM leaves WAIT there anyway.
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to a variable-latency data memory over a
// req/ack handshake, stalls upstream while waiting, and registers the MEM/WB outputs.
//   CLOCK, RESET_N        : clock, asynchronous active-low reset
//   *_In (EX/MEM)         : RegWriteEN, Mem2RegSEL, MemWriteEN, ALUResult, WriteData,
//                           RegWBAddr, PCPlus4
//   MemReq/WE/Addr/WData  : memory request side, held constant while waiting
//   MemRData_In/MemAck_In : memory response, ack is a single-cycle pulse
//   Stall_Out             : combinational hold for EX/MEM and earlier stages
//   RegWriteEN/WBAddr/WBData_Out : registered write-back results
//   BusErr_Out, MisalignErr_Out  : registered single-cycle error pulses
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              RegWriteEN_In,
  input  logic [1:0]        Mem2RegSEL_In,
  input  logic              MemWriteEN_In,
  input  logic [DATA_W-1:0] ALUResult_In,
  input  logic [DATA_W-1:0] WriteData_In,
  input  logic [4:0]        RegWBAddr_In,
  input  logic [DATA_W-1:0] PCPlus4_In,
  output logic              MemReq_Out,
  output logic              MemWE_Out,
  output logic [DATA_W-1:0] MemAddr_Out,
  output logic [DATA_W-1:0] MemWData_Out,
  input  logic [DATA_W-1:0] MemRData_In,
  input  logic              MemAck_In,
  output logic              Stall_Out,
  output logic              RegWriteEN_Out,
  output logic [4:0]        RegWBAddr_Out,
  output logic [DATA_W-1:0] RegWBData_Out,
  output logic              BusErr_Out,
  output logic              MisalignErr_Out
);

  state_t r_state, w_state_d;

  // Request latched at issue time; address kept without its always-zero low bits.
  logic              r_we;
  logic [DATA_W-3:0] r_addr_hi;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_rd;
  logic              r_rwe;
  logic [1:0]        r_sel;

  logic              r_wb_en;
  logic [4:0]        r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_bus_err;
  logic              r_misalign;

  logic              w_wb_en_d;
  logic [4:0]        w_wb_addr_d;
  logic [DATA_W-1:0] w_wb_data_d;
  logic              w_bus_err_d;
  logic              w_misalign_d;
  logic              w_stall;

  logic w_mem_op;
  logic w_aligned;
  logic w_issue;
  logic w_expired;
  logic w_pending_load;

  assign w_mem_op       = MemWriteEN_In | (Mem2RegSEL_In == SEL_MEM);
  assign w_aligned      = is_word_aligned(ALUResult_In[1:0]);
  assign w_issue        = (r_state == IDLE) & w_mem_op & w_aligned;
  // A latched write always behaves as a store, even if SEL also said "memory".
  assign w_pending_load = (r_sel == SEL_MEM) & ~r_we;

  mem_bus_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .i_clk     (CLOCK),
    .i_rst_n   (RESET_N),
    .i_clear   (w_issue),
    .i_enable  ((r_state == WAIT) & ~MemAck_In),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_d    = r_state;
    w_wb_en_d    = 1'b0;
    w_wb_addr_d  = '0;
    w_wb_data_d  = '0;
    w_bus_err_d  = 1'b0;
    w_misalign_d = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_mem_op) begin
          w_wb_en_d   = RegWriteEN_In;
          w_wb_addr_d = RegWBAddr_In;
          w_wb_data_d = (Mem2RegSEL_In == SEL_PC4) ? PCPlus4_In : ALUResult_In;
        end else if (w_aligned) begin
          w_state_d = WAIT;
          w_stall   = 1'b1;
        end else begin
          w_misalign_d = 1'b1;
        end
      end
      WAIT: begin
        // Ack is checked first so an ack on the terminal cycle still completes.
        if (MemAck_In) begin
          w_state_d   = IDLE;
          w_wb_addr_d = r_rd;
          if (w_pending_load) begin
            w_wb_en_d   = r_rwe;
            w_wb_data_d = MemRData_In;
          end
        end else if (w_expired) begin
          w_state_d   = IDLE;
          w_bus_err_d = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_addr_hi  <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_rwe      <= 1'b0;
      r_sel      <= SEL_ALU;
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_bus_err  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wb_en    <= w_wb_en_d;
      r_wb_addr  <= w_wb_addr_d;
      r_wb_data  <= w_wb_data_d;
      r_bus_err  <= w_bus_err_d;
      r_misalign <= w_misalign_d;
      if (w_issue) begin
        r_we      <= MemWriteEN_In;
        r_addr_hi <= ALUResult_In[DATA_W-1:2];
        r_wdata   <= WriteData_In;
        r_rd      <= RegWBAddr_In;
        r_rwe     <= RegWriteEN_In;
        r_sel     <= Mem2RegSEL_In;
      end
    end
  end

  assign MemReq_Out      = (r_state == WAIT);
  assign MemWE_Out       = r_we;
  assign MemAddr_Out     = {r_addr_hi, 2'b00};
  assign MemWData_Out    = r_wdata;
  // Gated by reset so upstream is released immediately even while an op is presented.
  assign Stall_Out       = RESET_N & w_stall;
  assign RegWriteEN_Out  = r_wb_en;
  assign RegWBAddr_Out   = r_wb_addr;
  assign RegWBData_Out   = r_wb_data;
  assign BusErr_Out      = r_bus_err;
  assign MisalignErr_Out = r_misalign;

endmodule
